accumulator: RTL and testbench



---
 rtl/accumulator_pkg.sv | 8 +
 rtl/counter_8bit.sv | 33 +++
 rtl/accumulator.sv | 40 ++++
 tb/tb_accumulator.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/accumulator_pkg.sv
// Shared width defaults for the accumulator and its companion counter source.
// Both modules import this package so their data widths agree.
package accumulator_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ACC_WIDTH  = 16;

endpackage : accumulator_pkg

// File: rtl/counter_8bit.sv
// Companion source: presents an incrementing byte on a valid/ready handshake.
// It advances only on a transfer, so data and valid stay put while ready is low.
module counter_8bit
  import accumulator_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  output logic                          valid,
  input  logic                          ready,
  output logic [DEFAULT_DATA_WIDTH-1:0] data
);

  logic                          r_valid;
  logic [DEFAULT_DATA_WIDTH-1:0] r_data;
  logic                          w_transfer;

  assign w_transfer = r_valid & ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= 1'b1;
      // The increment wraps 0xFF -> 0x00 on its own.
      if (w_transfer) r_data <= r_data + 1'b1;
    end
  end

  assign valid = r_valid;
  assign data  = r_data;

endmodule : counter_8bit

// File: rtl/accumulator.sv
// Running-sum sink: adds each accepted unsigned sample into a wrapping register.
// ready comes straight from a flop, so it never depends on valid in the same cycle.
module accumulator
  import accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  valid,
  output logic                  ready,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [ACC_WIDTH-1:0]  accumulated
);

  logic                 r_ready;
  logic [ACC_WIDTH-1:0] r_accumulated;
  logic                 w_transfer;
  logic [ACC_WIDTH-1:0] w_addend;

  assign w_transfer = valid & r_ready;
  assign w_addend   = ACC_WIDTH'(data);

  // NOTE: state flops use non-blocking assignment so every flop samples
  // pre-edge values; reset sits first so it overrides a simultaneous transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ready       <= 1'b0;
      r_accumulated <= '0;
    end else begin
      r_ready <= 1'b1;
      if (w_transfer) r_accumulated <= r_accumulated + w_addend;
    end
  end

  assign ready       = r_ready;
  assign accumulated = r_accumulated;

endmodule : accumulator

// File: tb/tb_accumulator.sv
// Bench for accumulator: counter-driven streams, a direct source with gaps and
// random traffic, all compared against a running-sum reference model.
module tb_accumulator;
  import accumulator_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        src_sel = 1'b1;
  logic        dir_valid = 1'b0;
  logic [7:0]  dir_data = '0;
  logic        c_valid, c_ready;
  logic [7:0]  c_data;
  logic        a_valid, a_ready;
  logic [7:0]  a_data;
  logic [15:0] acc;

  int n_checks = 0;
  int n_errors = 0;
  int exp_sum  = 0;
  int exp_cnt  = 0;
  bit exp_ready = 1'b0;

  always #5 clock = ~clock;

  assign a_valid = src_sel ? c_valid : dir_valid;
  assign a_data  = src_sel ? c_data  : dir_data;
  assign c_ready = src_sel ? a_ready : 1'b0;

  counter_8bit u_src (
    .clock (clock),
    .reset (reset),
    .valid (c_valid),
    .ready (c_ready),
    .data  (c_data)
  );

  accumulator #(
    .DATA_WIDTH (DEFAULT_DATA_WIDTH),
    .ACC_WIDTH  (DEFAULT_ACC_WIDTH)
  ) u_dut (
    .clock       (clock),
    .reset       (reset),
    .valid       (a_valid),
    .ready       (a_ready),
    .data        (a_data),
    .accumulated (acc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Entered and left at a falling edge.
  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) begin
      @(negedge clock);
      check("rst_acc", acc, 0);
      check("rst_ready", a_ready, 0);
      check("rst_cnt_valid", c_valid, 0);
      check("rst_cnt_data", c_data, 0);
    end
    reset     = 1'b0;
    exp_sum   = 0;
    exp_cnt   = 0;
    exp_ready = 1'b1;
    @(negedge clock);
    check("post_rst_ready", a_ready, 1);
    check("post_rst_acc", acc, 0);
  endtask

  // Counter-driven stream: expected data is the transfer index mod 256.
  task automatic stream(input int n);
    int xfers  = 0;
    int cycles = 0;
    while (xfers < n && cycles < 10000) begin
      check("stream_acc", acc, exp_sum);
      check("stream_ready", a_ready, 1);
      if (c_valid && a_ready) begin
        check("stream_data", c_data, exp_cnt % 256);
        exp_sum = (exp_sum + exp_cnt % 256) % 65536;
        exp_cnt++;
        xfers++;
      end
      @(negedge clock);
      cycles++;
    end
    check("stream_timeout", xfers, n);
  endtask

  // Direct single transfer or idle cycle, driven at a falling edge.
  task automatic direct(input bit v, input logic [7:0] d);
    dir_valid = v;
    dir_data  = d;
    if (v && exp_ready) exp_sum = (exp_sum + d) % 65536;
    @(negedge clock);
    dir_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and short stream.
    apply_reset(2);
    stream(5);
    check("short_sum", acc, 16'h000A);

    // Counter wrap: 256 transfers, then a zero sample that leaves the sum alone.
    stream(251);
    check("cnt_wrap_sum", acc, 16'h7F80);
    check("cnt_wrap_data", c_data, 8'h00);
    stream(1);
    check("zero_xfer_sum", acc, 16'h7F80);

    // Sum wrap over 1000 transfers.
    apply_reset(1);
    stream(1000);
    check("sum_wrap", acc, 16'hE72C);

    // Mid-stream reset, with the counter still presenting valid data.
    apply_reset(1);
    stream(10);
    check("mid_pre_sum", acc, 16'h002D);
    apply_reset(1);
    check("mid_cnt_restart", c_data, 8'h00);
    stream(10);
    check("mid_post_sum", acc, 16'h002D);

    // Direct source: a gap of three idle cycles between two samples.
    src_sel = 1'b0;
    apply_reset(1);
    direct(1'b1, 8'h10);
    check("gap_first", acc, 16'h0010);
    for (int i = 0; i < 3; i++) begin
      dir_data = 8'($urandom_range(0, 255));
      @(negedge clock);
      check("gap_hold", acc, 16'h0010);
    end
    direct(1'b1, 8'h20);
    check("gap_second", acc, 16'h0030);

    // Register wrap: 257 x 0xFF = 0xFFFF, then +1 wraps to zero.
    apply_reset(1);
    for (int i = 0; i < 257; i++) direct(1'b1, 8'hFF);
    check("acc_full", acc, 16'hFFFF);
    direct(1'b1, 8'h01);
    check("acc_wrap", acc, 16'h0000);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      check("rand_acc", acc, exp_sum);
      check("rand_ready", a_ready, exp_ready);
      reset     = ($urandom_range(0, 39) == 0);
      dir_valid = 1'($urandom_range(0, 1));
      dir_data  = 8'($urandom_range(0, 255));
      if (reset) begin
        exp_sum   = 0;
        exp_ready = 1'b0;
      end else begin
        if (dir_valid && exp_ready) exp_sum = (exp_sum + dir_data) % 65536;
        exp_ready = 1'b1;
      end
      @(negedge clock);
    end
    reset     = 1'b0;
    dir_valid = 1'b0;
    @(negedge clock);
    check("rand_final", acc, exp_sum);
    check("cnt_hold_data", c_data, 8'h00);
    check("cnt_hold_valid", c_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_accumulator
